branch_resolve_tracker: RTL and testbench

// - Resolution-side partner of the 2-way BTB predictor. Records each prediction issued at fetch
//   (PC, predicted taken, predicted target) in an in-order FIFO and pops the entry when the

---
 rtl/branch_resolve_tracker_pkg.sv | 22 ++
 rtl/branch_resolve_tracker_fifo.sv | 61 ++++++
 rtl/branch_resolve_tracker.sv | 133 +++++++++++++
 tb/tb_branch_resolve_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_tracker_pkg.sv
// Shared types for the branch resolution tracker.
// - entry_t    : one in-flight prediction recorded at fetch
// - btb_upd_t  : BTB stage-3 update bundle, shared with the BTB's inputs
package branch_resolve_tracker_pkg;

    localparam int ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        is_branch;
        logic        taken;
        logic        prev_taken;
        logic [31:0] target;
    } btb_upd_t;

endpackage

// File: rtl/branch_resolve_tracker_fifo.sv
// pred_fifo: DEPTH-entry register FIFO of in-flight predictions.
// Ports: clk, rst (sync, active-high), push/pop/clear strobes, push_entry,
//        head (oldest entry), full, empty.
// clear has priority over push and pop; full/empty derive from a count register.
module pred_fifo
    import branch_resolve_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  entry_t push_entry,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage slots carry no reset; validity is tracked solely by the pointers.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PTR_W'(gi)))
                    mem[gi] <= push_entry;
            end
        end
    endgenerate

endmodule

// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: records fetch-time BTB predictions and checks them
// against EX resolution in program order.
// Inputs : memory_stall, flush_in, push_* (fetch side), res_* (EX side).
// Outputs: push_ready, upd_* (BTB stage-3 update), mispredict, redirect_pc,
//          sync_err (sticky), br_count / miss_count (saturating statistics).
module branch_resolve_tracker
    import branch_resolve_tracker_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memory_stall,
    input  logic             flush_in,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic             push_taken,
    input  logic [31:0]      push_target,
    output logic             push_ready,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic             res_is_branch,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic [31:0]      upd_pc,
    output logic             upd_is_branch,
    output logic             upd_taken,
    output logic             upd_prev_taken,
    output logic [31:0]      upd_target,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             sync_err,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);
    entry_t           head;
    entry_t           push_entry;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             dir_miss;
    logic             alias_miss;
    logic             miss;
    logic             sync_hit;
    logic             clear;
    logic [31:0]      redirect_next;

    btb_upd_t         upd_reg;
    logic             mispredict_reg;
    logic [31:0]      redirect_reg;
    logic             sync_err_reg;
    logic [CNT_W-1:0] br_count_reg;
    logic [CNT_W-1:0] miss_count_reg;

    assign push_entry = '{pc: push_pc, pred_taken: push_taken, pred_target: push_target};

    assign pop  = res_valid & ~empty & ~memory_stall;
    assign push = push_valid & ~full & ~memory_stall;

    // Target only matters when both prediction and outcome are taken.
    assign dir_miss   = pop & res_is_branch &
                        ((head.pred_taken != res_taken) |
                         (head.pred_taken & res_taken & (head.pred_target != res_target)));
    // A taken prediction on a non-branch means the BTB hit on an aliased PC.
    assign alias_miss = pop & ~res_is_branch & head.pred_taken;
    assign miss       = dir_miss | alias_miss;

    assign sync_hit = res_valid & ~memory_stall & (empty | (res_pc != head.pc));

    // flush_in clears even under memory_stall; miss/sync_hit are already stall-gated.
    assign clear = flush_in | miss | sync_hit;

    always_comb begin
        redirect_next = res_pc + 32'd4;
        if (!sync_hit && res_is_branch && res_taken)
            redirect_next = res_target;
    end

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .push_entry (push_entry),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_reg        <= '0;
            mispredict_reg <= 1'b0;
            redirect_reg   <= '0;
            sync_err_reg   <= 1'b0;
            br_count_reg   <= '0;
            miss_count_reg <= '0;
        end else begin
            upd_reg.is_branch <= pop & res_is_branch;
            mispredict_reg    <= miss | sync_hit;
            if (pop) begin
                upd_reg.pc         <= res_pc;
                upd_reg.taken      <= res_taken;
                upd_reg.prev_taken <= head.pred_taken;
                upd_reg.target     <= res_target;
            end
            if (miss || sync_hit)
                redirect_reg <= redirect_next;
            if (sync_hit)
                sync_err_reg <= 1'b1;
            if (pop && res_is_branch && (br_count_reg != '1))
                br_count_reg <= br_count_reg + 1'b1;
            if (miss && (miss_count_reg != '1))
                miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign push_ready     = ~full;
    assign upd_pc         = upd_reg.pc;
    assign upd_is_branch  = upd_reg.is_branch;
    assign upd_taken      = upd_reg.taken;
    assign upd_prev_taken = upd_reg.prev_taken;
    assign upd_target     = upd_reg.target;
    assign mispredict     = mispredict_reg;
    assign redirect_pc    = redirect_reg;
    assign sync_err       = sync_err_reg;
    assign br_count       = br_count_reg;
    assign miss_count     = miss_count_reg;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Scoreboard bench for branch_resolve_tracker: stimulus pushes expected update
// records, a negedge monitor pops and compares on every upd_is_branch/mispredict.
module tb_branch_resolve_tracker;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             memory_stall, flush_in;
    logic             push_valid, push_taken;
    logic [31:0]      push_pc, push_target;
    logic             push_ready;
    logic             res_valid, res_is_branch, res_taken;
    logic [31:0]      res_pc, res_target;
    logic [31:0]      upd_pc, upd_target, redirect_pc;
    logic             upd_is_branch, upd_taken, upd_prev_taken, mispredict, sync_err;
    logic [CNT_W-1:0] br_count, miss_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        is_br;
        logic        misp;
        logic        chk_upd;
        logic [31:0] pc;
        logic        prev;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] redir;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_resolve_tracker #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .memory_stall(memory_stall), .flush_in(flush_in),
        .push_valid(push_valid), .push_pc(push_pc), .push_taken(push_taken),
        .push_target(push_target), .push_ready(push_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_is_branch(res_is_branch),
        .res_taken(res_taken), .res_target(res_target),
        .upd_pc(upd_pc), .upd_is_branch(upd_is_branch), .upd_taken(upd_taken),
        .upd_prev_taken(upd_prev_taken), .upd_target(upd_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .sync_err(sync_err),
        .br_count(br_count), .miss_count(miss_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any update/mispredict pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (upd_is_branch || mispredict)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse upd_is_branch=%0b mispredict=%0b pc=0x%0h",
                         upd_is_branch, mispredict, upd_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("UPD is_branch=%0b mispredict=%0b pc=0x%0h target=0x%0h redirect=0x%0h",
                         upd_is_branch, mispredict, upd_pc, upd_target, redirect_pc);
                chk("upd_is_branch", {31'd0, upd_is_branch}, {31'd0, e.is_br});
                chk("mispredict", {31'd0, mispredict}, {31'd0, e.misp});
                if (e.misp) chk("redirect_pc", redirect_pc, e.redir);
                if (e.chk_upd) begin
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_prev_taken", {31'd0, upd_prev_taken}, {31'd0, e.prev});
                    chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
                    chk("upd_target", upd_target, e.tgt);
                end
            end
        end
    end

    task automatic idle();
        memory_stall = 0; flush_in = 0;
        push_valid = 0; push_pc = 0; push_taken = 0; push_target = 0;
        res_valid = 0; res_pc = 0; res_is_branch = 0; res_taken = 0; res_target = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic [31:0] rpc, input logic rb, input logic rt,
                       input logic [31:0] rtg, input logic st, input logic fl);
        push_valid = pv; push_pc = ppc; push_taken = pt; push_target = ptg;
        res_valid = rv; res_pc = rpc; res_is_branch = rb; res_taken = rt; res_target = rtg;
        memory_stall = st; flush_in = fl;
        tick();
        idle();
    endtask

    task automatic push_only(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        cyc(1, pc, t, tg, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic b, input logic t, input logic [31:0] tg);
        cyc(0, 0, 0, 0, 1, pc, b, t, tg, 0, 0);
    endtask

    task automatic expect_upd(input logic is_br, input logic misp, input logic chk_upd,
                              input logic [31:0] pc, input logic prev, input logic taken,
                              input logic [31:0] tgt, input logic [31:0] redir);
        exp_q.push_back('{is_br: is_br, misp: misp, chk_upd: chk_upd, pc: pc, prev: prev,
                          taken: taken, tgt: tgt, redir: redir});
    endtask

    task automatic chk_cnt(input string tag, input int br, input int miss);
        chk({tag, "_br_count"}, 32'(br_count), 32'(br));
        chk({tag, "_miss_count"}, 32'(miss_count), 32'(miss));
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();

        // Reset state
        chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_upd_is_branch", {31'd0, upd_is_branch}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_sync_err", {31'd0, sync_err}, 32'd0);
        chk_cnt("rst", 0, 0);

        // Correct not-taken prediction
        push_only(32'h100, 0, 32'h0);
        expect_upd(1, 0, 1, 32'h100, 0, 0, 32'h104, 32'h0);
        resolve(32'h100, 1, 0, 32'h104);
        chk_cnt("nt_ok", 1, 0);

        // Taken with wrong target
        push_only(32'h200, 1, 32'h300);
        expect_upd(1, 1, 1, 32'h200, 1, 1, 32'h340, 32'h340);
        resolve(32'h200, 1, 1, 32'h340);
        chk_cnt("tgt_miss", 2, 1);

        // Fill, overflow push dropped, drain in order; full+pop still refuses the push
        push_only(32'h400, 0, 0);
        push_only(32'h410, 0, 0);
        push_only(32'h420, 0, 0);
        chk("three_push_ready", {31'd0, push_ready}, 32'd1);
        push_only(32'h430, 0, 0);
        chk("full_push_ready", {31'd0, push_ready}, 32'd0);
        push_only(32'h440, 0, 0);
        chk("overflow_push_ready", {31'd0, push_ready}, 32'd0);
        expect_upd(1, 0, 1, 32'h400, 0, 0, 32'h404, 32'h0);
        cyc(1, 32'h450, 0, 0, 1, 32'h400, 1, 0, 32'h404, 0, 0);
        chk("after_pop_push_ready", {31'd0, push_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            logic [31:0] pc;
            pc = 32'h400 + 32'(i) * 32'h10;
            expect_upd(1, 0, 1, pc, 0, 0, pc + 32'd4, 32'h0);
            resolve(pc, 1, 0, pc + 32'd4);
        end
        chk_cnt("drain", 6, 1);

        // Mispredict with a simultaneous push clears younger entries
        push_only(32'h500, 0, 0);
        push_only(32'h510, 1, 32'h600);
        push_only(32'h520, 0, 0);
        expect_upd(1, 1, 1, 32'h500, 0, 1, 32'h580, 32'h580);
        cyc(1, 32'h530, 0, 0, 1, 32'h500, 1, 1, 32'h580, 0, 0);
        chk_cnt("dir_miss", 7, 2);
        push_only(32'h700, 0, 0);
        expect_upd(1, 0, 1, 32'h700, 0, 0, 32'h704, 32'h0);
        resolve(32'h700, 1, 0, 32'h704);
        chk_cnt("after_clear", 8, 2);

        // Stale alias: non-branch predicted taken
        push_only(32'h800, 1, 32'h900);
        expect_upd(0, 1, 1, 32'h800, 1, 0, 32'h804, 32'h804);
        resolve(32'h800, 0, 0, 32'h804);
        chk_cnt("alias", 8, 3);

        // memory_stall freezes everything
        push_only(32'h900, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 32'hA00, 0, 0, 1, 32'h900, 1, 0, 32'h904, 1, 0);
        chk_cnt("stall", 8, 3);
        expect_upd(1, 0, 1, 32'h900, 0, 0, 32'h904, 32'h0);
        resolve(32'h900, 1, 0, 32'h904);
        chk_cnt("post_stall", 9, 3);
        push_only(32'hB00, 0, 0);
        push_only(32'hB10, 0, 0);
        push_only(32'hB20, 0, 0);
        chk("post_stall_push_ready", {31'd0, push_ready}, 32'd1);

        // Flush with a simultaneous pop still updates
        expect_upd(1, 0, 1, 32'hB00, 0, 0, 32'hB04, 32'h0);
        cyc(0, 0, 0, 0, 1, 32'hB00, 1, 0, 32'hB04, 0, 1);
        chk_cnt("flush_pop", 10, 3);

        // Flush wins over stall for the clear
        push_only(32'hC00, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Resolve on empty: sync error, no update pulse
        expect_upd(0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h108);
        resolve(32'h104, 1, 0, 32'h108);
        chk("empty_sync_err", {31'd0, sync_err}, 32'd1);
        chk_cnt("empty_res", 10, 3);

        // PC mismatch against head
        push_only(32'h100, 0, 0);
        expect_upd(1, 1, 1, 32'h104, 0, 0, 32'h108, 32'h108);
        resolve(32'h104, 1, 0, 32'h108);
        chk("mismatch_sync_err", {31'd0, sync_err}, 32'd1);
        chk_cnt("mismatch", 11, 3);
        tick(); tick();
        chk("sticky_sync_err", {31'd0, sync_err}, 32'd1);

        // Reset mid-operation drops in-flight entries
        push_only(32'h100, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("rst2_sync_err", {31'd0, sync_err}, 32'd0);
        chk("rst2_push_ready", {31'd0, push_ready}, 32'd1);
        chk("rst2_redirect_pc", redirect_pc, 32'd0);
        chk_cnt("rst2", 0, 0);
        push_only(32'h120, 0, 0);
        expect_upd(1, 0, 1, 32'h120, 0, 0, 32'h124, 32'h0);
        resolve(32'h120, 1, 0, 32'h124);
        chk("rst2_no_sync_err", {31'd0, sync_err}, 32'd0);
        chk_cnt("rst2_after", 1, 0);

        tick(); tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
